dac_interface_ad5724: RTL and testbench

Serial write-side interface for the AD5724 quad DAC that drives the memboard bias and programming voltages. It accepts a one-cycle command on the shared `cs`/`op`/`addr` register bus and serialises a 24-bit frame MSB-first onto SYNC/SCLK/DIN. It optionally strobes LDAC to update the outputs, and reports completion on `rdy` and `state`. It is the transmit counterpart of the ADC capture interface and uses the same bus and SCLK phase conventions.

---
 rtl/dac_pkg.sv | 34 +++
 rtl/dac_interface_ad5724_if.sv | 17 +
 rtl/spi_tx_shifter.sv | 81 ++++++++
 rtl/dac_interface_ad5724.sv | 169 ++++++++++++++++
 tb/tb_dac_interface_ad5724.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the AD5724 DAC write interface: FSM state encodings,
// register-bus op bit indices, default timing constants and the frame layout.
package dac_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SETUP = 4'd2,
    S_QUIET = 4'd3,
    S_SHIFT = 4'd5,
    S_HOLD  = 4'd6,
    S_LDAC  = 4'd7
  } dac_state_e;

  localparam int unsigned OP_RST = 0;
  localparam int unsigned OP_EN  = 1;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned STATE_W = 4;

  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_HOLD_DEF  = 2;
  localparam int unsigned T_LDAC_DEF  = 2;
  localparam int unsigned T_QUIET_DEF = 3;
  localparam int unsigned NBIT_DEF    = 24;

  // One DAC frame: control byte (R/W, 0, REG[2:0], A[2:0]) then data word.
  typedef struct packed {
    logic [ADDR_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } dac_frame_t;

endpackage

// File: rtl/dac_interface_ad5724_if.sv
// Register-bus bundle for the DAC write interface.
//   cs, op, addr, data_in : command from the bus master (valid while cs=1)
//   rdy, state            : status back to the master
interface dac_interface_ad5724_if;
  import dac_pkg::*;

  logic               cs;
  logic [OP_W-1:0]    op;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data_in;
  logic               rdy;
  logic [STATE_W-1:0] state;

  modport master (output cs, op, addr, data_in, input rdy, state);
  modport slave  (input cs, op, addr, data_in, output rdy, state);

endinterface

// File: rtl/spi_tx_shifter.sv
// Serialiser for one DAC frame, MSB first, with a 4-cycle bit period.
//   clk, rst   : clock, async active-high reset
//   clear_i    : return SCLK/DIN to idle and drop any frame in progress
//   load_i     : capture frame_i and rewind the counters
//   enable_i   : advance the bit-period phase counter by one
//   frame_i    : frame to transmit
//   sclk_o     : serial clock, idles high, falls at phase 2
//   din_o      : serial data, updated at phase 0
//   done_o     : high once the last bit period has fully elapsed
module spi_tx_shifter #(
  parameter int unsigned NBIT = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            enable_i,
  input  logic [NBIT-1:0] frame_i,
  output logic            sclk_o,
  output logic            din_o,
  output logic            done_o
);

  localparam int unsigned BCNT_W = $clog2(NBIT + 1);

  logic [NBIT-1:0]   sr_q;
  logic [1:0]        phase_q;
  logic [BCNT_W-1:0] bit_cnt_q;
  logic              sclk_q;
  logic              din_q;
  logic              done_q;

  // Phase 0 presents the next bit, phase 2 drops SCLK so the DAC samples it
  // two cycles after DIN settled; DIN then holds for two more cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      phase_q   <= 2'd0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      sr_q      <= '0;
      phase_q   <= 2'd0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (load_i) begin
      sr_q      <= frame_i;
      phase_q   <= 2'd0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else if (enable_i && !done_q) begin
      phase_q <= phase_q + 2'd1;
      case (phase_q)
        2'd0: begin
          sclk_q <= 1'b1;
          din_q  <= sr_q[NBIT-1];
        end
        2'd2: begin
          sclk_q    <= 1'b0;
          sr_q      <= {sr_q[NBIT-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
        end
        2'd3: begin
          // Done only after the tail of the last bit period, so the final
          // falling edge still gets its DIN hold time.
          if (bit_cnt_q == BCNT_W'(NBIT)) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sclk_o = sclk_q;
  assign din_o  = din_q;
  assign done_o = done_q;

endmodule

// File: rtl/dac_interface_ad5724.sv
// AD5724 quad-DAC write interface: takes a one-cycle command from the
// cs/op/addr register bus and sends {addr, data_in} as a 24-bit frame on
// SYNC/SCLK/DIN, then optionally strobes LDAC.
//   clk, rst : clock, async active-high reset
//   bus      : register bus (slave side) with rdy/state status
//   SYNC     : frame sync, active low
//   SCLK     : serial clock, idles high
//   DIN      : serial data
//   LDAC     : load strobe, active low
// Build option: define DAC_LDAC_PULSE_EN to pulse LDAC after every frame;
// otherwise LDAC is held low and the DAC updates on the SYNC rising edge.
module dac_interface_ad5724
  import dac_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_LDAC  = T_LDAC_DEF,
  parameter int unsigned T_QUIET = T_QUIET_DEF,
  parameter int unsigned NBIT    = NBIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  dac_interface_ad5724_if.slave  bus,
  output logic                   SYNC,
  output logic                   SCLK,
  output logic                   DIN,
  output logic                   LDAC
);

  localparam int unsigned T_MAX01 = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned T_MAX23 = (T_LDAC > T_QUIET) ? T_LDAC : T_QUIET;
  localparam int unsigned T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
  localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

  dac_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_q;
  logic             sync_q;
`ifdef DAC_LDAC_PULSE_EN
  logic             ldac_q;
`endif

  dac_frame_t frame_c;
  logic       soft_rst_c;
  logic       start_c;
  logic       setup_last_c;
  logic       hold_last_c;
  logic       shift_done;
  logic       unused_op_c;

  // Bus decode; soft reset wins over start when both bits are set.
  assign soft_rst_c   = bus.cs & bus.op[OP_RST];
  assign start_c      = bus.cs & bus.op[OP_EN] & ~bus.op[OP_RST] &
                        rdy_q & (state_q == S_IDLE);
  assign unused_op_c  = ^bus.op[OP_W-1:2];
  assign frame_c      = '{ctrl: bus.addr, data: bus.data_in};

  assign setup_last_c = (state_q == S_SETUP) && (cnt_q == CNT_W'(T_SETUP - 1));
  assign hold_last_c  = (state_q == S_HOLD)  && (cnt_q == CNT_W'(T_HOLD - 1));

  // The shifter starts on the last setup cycle so bit 0 lands on DIN on the
  // same edge that enters S_SHIFT.
  spi_tx_shifter #(.NBIT(NBIT)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (soft_rst_c | hold_last_c),
    .load_i   (start_c),
    .enable_i (setup_last_c | (state_q == S_SHIFT)),
    .frame_i  (NBIT'(frame_c)),
    .sclk_o   (SCLK),
    .din_o    (DIN),
    .done_o   (shift_done)
  );

  // Frame sequencer: SYNC, LDAC, rdy and the timing counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      sync_q  <= 1'b1;
`ifdef DAC_LDAC_PULSE_EN
      ldac_q  <= 1'b1;
`endif
    end else if (soft_rst_c) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      sync_q  <= 1'b1;
`ifdef DAC_LDAC_PULSE_EN
      ldac_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (start_c) begin
            rdy_q   <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (setup_last_c) begin
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (shift_done) begin
            cnt_q   <= '0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_last_c) begin
            sync_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef DAC_LDAC_PULSE_EN
            ldac_q  <= 1'b0;
            state_q <= S_LDAC;
`else
            state_q <= S_QUIET;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef DAC_LDAC_PULSE_EN
        S_LDAC: begin
          if (cnt_q == CNT_W'(T_LDAC - 1)) begin
            ldac_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_QUIET;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_QUIET: begin
          if (cnt_q == CNT_W'(T_QUIET - 1)) begin
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign SYNC      = sync_q;
  assign bus.rdy   = rdy_q;
  assign bus.state = state_q;
`ifdef DAC_LDAC_PULSE_EN
  assign LDAC      = ldac_q;
`else
  assign LDAC      = 1'b0;
`endif

endmodule

// File: tb/tb_dac_interface_ad5724.sv
// Self-checking bench for dac_interface_ad5724 (default timing parameters).
// Works with or without DAC_LDAC_PULSE_EN defined.
module tb_dac_interface_ad5724;

  localparam int T_SETUP = 2;
  localparam int T_HOLD  = 2;
  localparam int T_LDAC  = 2;
  localparam int T_QUIET = 3;
  localparam int NBIT    = 24;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SETUP = 4'd2;

  // Timeline derived from the frame rules: setup, 4 clk per bit, hold, quiet.
  localparam int FIRST_FALL = T_SETUP + 2;
  localparam int SYNC_LOW   = T_SETUP + 4 * NBIT + T_HOLD;
`ifdef DAC_LDAC_PULSE_EN
  localparam int BUSY       = SYNC_LOW + T_LDAC + T_QUIET;
  localparam logic LDAC_RST = 1'b1;
`else
  localparam int BUSY       = SYNC_LOW + T_QUIET;
  localparam logic LDAC_RST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SYNC, SCLK, DIN, LDAC;

  dac_interface_ad5724_if bus();

  dac_interface_ad5724 dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .SYNC (SYNC),
    .SCLK (SCLK),
    .DIN  (DIN),
    .LDAC (LDAC)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    bit          churn;
    bit          reissue;
    logic [23:0] exp_frame;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The DAC sees exactly the control byte followed by the data word.
  function automatic logic [23:0] model_frame(input logic [7:0] a, input logic [15:0] d);
    return {a, d};
  endfunction

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (bus.rdy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_rdy_wait"}, 32'(bus.rdy), 32'd1);
  endtask

  task automatic idle_bus();
    bus.cs = 1'b0;
    bus.op = 4'h0;
  endtask

  // Sends one frame and observes it pin by pin until rdy returns.
  task automatic write_frame(input string tag, input logic [7:0] a, input logic [15:0] d,
                             input bit churn, input bit reissue, input logic [23:0] exp_frame);
    logic [23:0] got = '0;
    int nfall = 0, first_fall = -1, sync_low = 0, sync_rise = -1, busy = -1;
    int ldac_low = 0, ldac_start = -1, ldac_bad = 0, reentry = 0, margin_bad = 0;
    int last_din_chg = 0, last_fall = -100;
    logic prev_sclk, prev_din, prev_sync;
    bit done = 1'b0;

    wait_rdy(tag);
    bus.cs = 1'b1; bus.op = 4'h2; bus.addr = a; bus.data_in = d;
    tick();                                   // E0
    check({tag, "_sync_at_e0"}, 32'(SYNC), 32'd0);
    check({tag, "_rdy_at_e0"}, 32'(bus.rdy), 32'd0);
    check({tag, "_state_at_e0"}, 32'(bus.state), 32'(ST_SETUP));
    if (SYNC === 1'b0) sync_low = 1;
    prev_sclk = SCLK; prev_din = DIN; prev_sync = SYNC;
    bus.op = 4'h0;
    bus.cs = churn;

    for (int k = 1; k <= 300 && !done; k++) begin
      if (churn) begin
        bus.data_in = 16'($urandom);
        bus.addr    = 8'($urandom);
      end
      if (reissue && k == 40) begin
        bus.cs = 1'b1; bus.op = 4'h2; bus.addr = ~a; bus.data_in = ~d;
      end else if (reissue && k == 41) begin
        bus.cs = churn; bus.op = 4'h0;
      end
      tick();
      if (SYNC === 1'b0) sync_low++;
      if (prev_sync === 1'b0 && SYNC === 1'b1) sync_rise = k;
      if (DIN !== prev_din) begin
        if (k - last_fall < 2) margin_bad++;
        last_din_chg = k;
      end
      if (prev_sclk === 1'b1 && SCLK === 1'b0) begin
        got = {got[22:0], DIN};
        nfall++;
        if (nfall == 1) first_fall = k;
        if (k - last_din_chg < 2) margin_bad++;
        last_fall = k;
      end
`ifdef DAC_LDAC_PULSE_EN
      if (LDAC === 1'b0) begin
        ldac_low++;
        if (ldac_start < 0) ldac_start = k;
      end
`else
      if (LDAC !== 1'b0) ldac_bad++;
`endif
      if (k >= T_SETUP && bus.state === ST_SETUP) reentry++;
      if (bus.rdy === 1'b1) begin
        busy = k;
        done = 1'b1;
      end
      prev_sclk = SCLK; prev_din = DIN; prev_sync = SYNC;
    end
    idle_bus();

    check({tag, "_frame"}, 32'(got), 32'(exp_frame));
    check({tag, "_falls"}, 32'(nfall), 32'(NBIT));
    check({tag, "_first_fall"}, 32'(first_fall), 32'(FIRST_FALL));
    check({tag, "_sync_low"}, 32'(sync_low), 32'(SYNC_LOW));
    check({tag, "_busy"}, 32'(busy), 32'(BUSY));
    check({tag, "_din_margin"}, 32'(margin_bad), 32'd0);
    check({tag, "_no_restart"}, 32'(reentry), 32'd0);
`ifdef DAC_LDAC_PULSE_EN
    check({tag, "_ldac_width"}, 32'(ldac_low), 32'(T_LDAC));
    check({tag, "_ldac_after_sync"}, 32'(ldac_start >= sync_rise && sync_rise > 0), 32'd1);
`else
    check({tag, "_ldac_tied_low"}, 32'(ldac_bad), 32'd0);
`endif
  endtask

  task automatic start_only(input logic [7:0] a, input logic [15:0] d);
    wait_rdy("start");
    bus.cs = 1'b1; bus.op = 4'h2; bus.addr = a; bus.data_in = d;
    tick();
    idle_bus();
  endtask

  vec_t vecs[4];

  initial begin
    int nfall;
    int ldac_bad;
    logic prev_sclk;
    logic [7:0]  ra;
    logic [15:0] rd;

    vecs[0] = '{addr: 8'h03, data: 16'hA5C3, churn: 1'b0, reissue: 1'b0, exp_frame: 24'h03A5C3};
    vecs[1] = '{addr: 8'h00, data: 16'h0FFF, churn: 1'b0, reissue: 1'b0, exp_frame: 24'h000FFF};
    vecs[2] = '{addr: 8'h1F, data: 16'h8001, churn: 1'b0, reissue: 1'b1, exp_frame: 24'h1F8001};
    vecs[3] = '{addr: 8'hE7, data: 16'h5A5A, churn: 1'b1, reissue: 1'b0, exp_frame: 24'hE75A5A};

    bus.cs = 1'b0; bus.op = 4'h0; bus.addr = 8'h00; bus.data_in = 16'h0000;

    // Reset values while rst is held.
    repeat (3) tick();
    check("rst_sync", 32'(SYNC), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd1);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_ldac", 32'(LDAC), 32'(LDAC_RST));
    check("rst_rdy", 32'(bus.rdy), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();
    check("rdy_after_rst", 32'(bus.rdy), 32'd1);

    // Directed frames from the table.
    foreach (vecs[i])
      write_frame($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
                  vecs[i].churn, vecs[i].reissue, vecs[i].exp_frame);

    // Random frames against the frame model.
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rd = 16'($urandom);
      write_frame($sformatf("rnd%0d", i), ra, rd, 1'($urandom_range(0, 1)), 1'b0,
                  model_frame(ra, rd));
    end

    // Soft reset and start in the same cycle: soft reset wins.
    wait_rdy("prio");
    bus.cs = 1'b1; bus.op = 4'h3; bus.addr = 8'h12; bus.data_in = 16'h3456;
    tick();
    idle_bus();
    check("prio_sync", 32'(SYNC), 32'd1);
    check("prio_state", 32'(bus.state), 32'(ST_IDLE));
    check("prio_rdy", 32'(bus.rdy), 32'd0);
    tick();
    check("prio_rdy_back", 32'(bus.rdy), 32'd1);

    // Soft reset right after the 10th falling edge.
    start_only(8'h55, 16'hAAAA);
    nfall = 0;
    prev_sclk = SCLK;
    for (int k = 0; k < 200 && nfall < 10; k++) begin
      tick();
      if (prev_sclk === 1'b1 && SCLK === 1'b0) nfall++;
      prev_sclk = SCLK;
    end
    check("srst_reached_fall10", 32'(nfall), 32'd10);
    check("srst_sclk_low_before", 32'(SCLK), 32'd0);
    bus.cs = 1'b1; bus.op = 4'h1;
    tick();
    idle_bus();
    check("srst_sync", 32'(SYNC), 32'd1);
    check("srst_sclk", 32'(SCLK), 32'd1);
    check("srst_state", 32'(bus.state), 32'(ST_IDLE));
    check("srst_rdy_low", 32'(bus.rdy), 32'd0);
    ldac_bad = (LDAC !== LDAC_RST) ? 1 : 0;
    tick();
    check("srst_rdy_back", 32'(bus.rdy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (LDAC !== LDAC_RST || SYNC !== 1'b1) ldac_bad++;
      tick();
    end
    check("srst_no_ldac_pulse", 32'(ldac_bad), 32'd0);
    write_frame("after_srst", 8'h3C, 16'hC3C3, 1'b0, 1'b0, 24'h3CC3C3);

    // Async reset between clock edges in the middle of S_SHIFT.
    start_only(8'hFF, 16'hFFFF);
    repeat (28) tick();
    check("arst_sync_before", 32'(SYNC), 32'd0);
    check("arst_din_before", 32'(DIN), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_sync", 32'(SYNC), 32'd1);
    check("arst_sclk", 32'(SCLK), 32'd1);
    check("arst_din", 32'(DIN), 32'd0);
    check("arst_ldac", 32'(LDAC), 32'(LDAC_RST));
    check("arst_rdy", 32'(bus.rdy), 32'd0);
    check("arst_state", 32'(bus.state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("arst_rdy_back", 32'(bus.rdy), 32'd1);
    write_frame("after_arst", 8'h07, 16'h1234, 1'b0, 1'b0, 24'h071234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
